// File: rtl/ahb3lite_arbiter.sv
// Round-robin AHB3-lite bus arbiter: tracks burst beats on the shared bus and
// moves a registered one-hot grant only at legal transfer boundaries.
module ahb3lite_arbiter #(
    parameter int NMASTERS = 2,
    parameter int PARK     = 0
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [NMASTERS-1:0]         REQ,
    input  logic [1:0]                  HTRANS,
    input  logic [2:0]                  HBURST,
    input  logic                        HMASTLOCK,
    input  logic                        HREADY,
    output logic [NMASTERS-1:0]         GNT,
    output logic [$clog2(NMASTERS)-1:0] HMASTER,
    output logic [$clog2(NMASTERS)-1:0] HMASTER_D
);

    localparam int MW = $clog2(NMASTERS);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BU_SINGLE = 3'd0;
    localparam logic [2:0] BU_INCR   = 3'd1;
    localparam logic [2:0] BU_WRAP4  = 3'd2;
    localparam logic [2:0] BU_INCR4  = 3'd3;
    localparam logic [2:0] BU_WRAP8  = 3'd4;
    localparam logic [2:0] BU_INCR8  = 3'd5;
    localparam logic [2:0] BU_WRAP16 = 3'd6;
    localparam logic [2:0] BU_INCR16 = 3'd7;

    localparam logic [NMASTERS-1:0] GNT_RST   = NMASTERS'(1) << PARK;
    localparam logic [MW-1:0]       OWNER_RST = MW'(PARK);

    logic [NMASTERS-1:0] gnt_q, gnt_d;
    logic [MW-1:0]       owner_q, owner_d;
    logic [MW-1:0]       data_owner_q, data_owner_d;
    logic [3:0]          cnt_q, cnt_d;

    logic [3:0]          cnt_upd;
    logic                bnd;
    logic                win_found;
    logic [MW-1:0]       win_idx;
    int                  cand;

    // Beats still to come in the current fixed-length burst after this one.
    always_comb begin
        cnt_upd = cnt_q;
        case (HTRANS)
            TR_IDLE:   cnt_upd = 4'd0;
            TR_BUSY:   cnt_upd = cnt_q;
            TR_NONSEQ: begin
                case (HBURST)
                    BU_WRAP4,  BU_INCR4:  cnt_upd = 4'd3;
                    BU_WRAP8,  BU_INCR8:  cnt_upd = 4'd7;
                    BU_WRAP16, BU_INCR16: cnt_upd = 4'd15;
                    default:              cnt_upd = 4'd0;
                endcase
            end
            TR_SEQ:    cnt_upd = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
            default:   cnt_upd = cnt_q;
        endcase
    end

    // Undefined-length INCR bursts may be cut at any beat; fixed bursts only at their last beat.
    always_comb begin
        bnd = 1'b0;
        if (HREADY && !HMASTLOCK) begin
            if (HTRANS == TR_IDLE)
                bnd = 1'b1;
            else if (HTRANS == TR_NONSEQ && HBURST == BU_SINGLE)
                bnd = 1'b1;
            else if (HTRANS == TR_SEQ && cnt_q == 4'd1)
                bnd = 1'b1;
            else if ((HTRANS == TR_NONSEQ || HTRANS == TR_SEQ) && HBURST == BU_INCR)
                bnd = 1'b1;
        end
    end

    // Search starts just past the current owner so the owner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = owner_q;
        cand      = 0;
        for (int s = 1; s <= NMASTERS; s++) begin
            cand = int'(owner_q) + s;
            if (cand >= NMASTERS)
                cand = cand - NMASTERS;
            if (!win_found && REQ[MW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = MW'(cand);
            end
        end
    end

    always_comb begin
        owner_d      = owner_q;
        data_owner_d = data_owner_q;
        cnt_d        = cnt_q;
        gnt_d        = '0;
        if (bnd && win_found)
            owner_d = win_idx;
        if (HREADY) begin
            data_owner_d = owner_q;
            cnt_d        = cnt_upd;
        end
        if (owner_d != owner_q)
            cnt_d = 4'd0;
        gnt_d[owner_d] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            gnt_q        <= GNT_RST;
            owner_q      <= OWNER_RST;
            data_owner_q <= OWNER_RST;
            cnt_q        <= 4'd0;
        end else begin
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            data_owner_q <= data_owner_d;
            cnt_q        <= cnt_d;
        end
    end

    assign GNT       = gnt_q;
    assign HMASTER   = owner_q;
    assign HMASTER_D = data_owner_q;

endmodule

// File: tb/tb_ahb3lite_arbiter.sv
// Self-checking bench for ahb3lite_arbiter: directed scenarios on 2- and 4-master
// instances plus randomized traffic against a burst-length/round-robin model.
module tb_ahb3lite_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] req2;
    logic [3:0] req4;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hlock;
    logic       hready;

    logic [1:0] gnt2;
    logic       hm2, hmd2;
    logic [3:0] gnt4;
    logic [1:0] hm4, hmd4;

    int checks = 0;
    int errors = 0;

    // model state per instance: [0] = 2 masters, [1] = 4 masters
    int m_own[2];
    int m_down[2];
    int m_left[2];

    ahb3lite_arbiter #(.NMASTERS(2), .PARK(0)) d2 (
        .CLK(clk), .RESET(rst), .REQ(req2), .HTRANS(htrans), .HBURST(hburst),
        .HMASTLOCK(hlock), .HREADY(hready), .GNT(gnt2), .HMASTER(hm2), .HMASTER_D(hmd2)
    );

    ahb3lite_arbiter #(.NMASTERS(4), .PARK(0)) d4 (
        .CLK(clk), .RESET(rst), .REQ(req4), .HTRANS(htrans), .HBURST(hburst),
        .HMASTLOCK(hlock), .HREADY(hready), .GNT(gnt4), .HMASTER(hm4), .HMASTER_D(hmd4)
    );

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int n;
            int rq;
            int len;
            bit bnd;
            n  = (k == 0) ? 2 : 4;
            rq = (k == 0) ? int'(req2) : int'(req4);
            if (rst) begin
                m_own[k] = 0; m_down[k] = 0; m_left[k] = 0;
            end else if (hready) begin
                bnd = !hlock && (htrans == 2'b00 ||
                                 (htrans == 2'b10 && hburst == 3'd0) ||
                                 (htrans == 2'b11 && m_left[k] == 1) ||
                                 (htrans[1] && hburst == 3'd1));
                m_down[k] = m_own[k];
                len = (hburst < 3'd2) ? 1 : (1 << ((hburst >> 1) + 1));
                case (htrans)
                    2'b00: m_left[k] = 0;
                    2'b10: m_left[k] = len - 1;
                    2'b11: if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
                    default: ;
                endcase
                if (bnd) begin
                    for (int s = 1; s <= n; s++) begin
                        if (rq[(m_own[k] + s) % n]) begin
                            m_own[k]  = (m_own[k] + s) % n;
                            m_left[k] = 0;
                            break;
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req2 = 2'b00; req4 = 4'b0000; htrans = 2'b00; hburst = 3'd0;
        hlock = 1'b0; hready = 1'b1;
        tick();
        checks++;
        if (gnt2 !== 2'b01 || hm2 !== 1'b0 || hmd2 !== 1'b0 || gnt4 !== 4'b0001) begin
            errors++;
            $display("FAIL reset: gnt2=%b hm2=%0d hmd2=%0d gnt4=%b, want 01 0 0 0001", gnt2, hm2, hmd2, gnt4);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (gnt2 !== 2'b01 || hm2 !== 1'b0 || hmd2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: gnt=%b hm=%0d hmd=%0d, want 01 0 0", i, gnt2, hm2, hmd2);
            end
        end
    endtask

    task automatic test_incr4();
        logic [1:0] eg;
        logic       ed;
        req2 = 2'b11; hburst = 3'd3;
        for (int i = 0; i < 5; i++) begin
            htrans = (i == 0) ? 2'b10 : ((i < 4) ? 2'b11 : 2'b00);
            tick();
            eg = (i == 3) ? 2'b10 : 2'b01;
            ed = (i == 4);
            checks++;
            if (gnt2 !== eg || hmd2 !== ed) begin
                errors++;
                $display("FAIL incr4[%0d]: gnt=%b hmd=%0d, want %b %0d", i, gnt2, hmd2, eg, ed);
            end
        end
    endtask

    task automatic test_alternate();
        logic prev;
        logic eh;
        req2 = 2'b11; htrans = 2'b10; hburst = 3'd0;
        prev = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            eh = (i % 2 == 0);
            checks++;
            if (hm2 !== eh || gnt2 !== (eh ? 2'b10 : 2'b01) || hmd2 !== prev) begin
                errors++;
                $display("FAIL alternate[%0d]: gnt=%b hm=%0d hmd=%0d, want hm=%0d hmd=%0d", i, gnt2, hm2, hmd2, eh, prev);
            end
            prev = eh;
        end
    endtask

    task automatic test_hready_stall();
        req2 = 2'b00; htrans = 2'b00; hready = 1'b1;
        tick();
        checks++;
        if (gnt2 !== 2'b01 || hmd2 !== 1'b0) begin
            errors++;
            $display("FAIL stall_settle: gnt=%b hmd=%0d, want 01 0", gnt2, hmd2);
        end
        req2 = 2'b10; hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gnt2 !== 2'b01 || hm2 !== 1'b0 || hmd2 !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: gnt=%b hm=%0d hmd=%0d, want 01 0 0", i, gnt2, hm2, hmd2);
            end
        end
        hready = 1'b1;
        tick();
        checks++;
        if (gnt2 !== 2'b10 || hm2 !== 1'b1 || hmd2 !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: gnt=%b hm=%0d hmd=%0d, want 10 1 0", gnt2, hm2, hmd2);
        end
        tick();
        checks++;
        if (gnt2 !== 2'b10 || hmd2 !== 1'b1) begin
            errors++;
            $display("FAIL stall_after: gnt=%b hmd=%0d, want 10 1", gnt2, hmd2);
        end
    endtask

    task automatic test_lock();
        req2 = 2'b01; htrans = 2'b00;
        tick();
        checks++;
        if (gnt2 !== 2'b01) begin
            errors++;
            $display("FAIL lock_setup: gnt=%b, want 01", gnt2);
        end
        req2 = 2'b11; hlock = 1'b1; htrans = 2'b10; hburst = 3'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (gnt2 !== 2'b01) begin
                errors++;
                $display("FAIL lock_hold[%0d]: gnt=%b, want 01", i, gnt2);
            end
        end
        hlock = 1'b0; htrans = 2'b00;
        tick();
        checks++;
        if (gnt2 !== 2'b10) begin
            errors++;
            $display("FAIL lock_release: gnt=%b, want 10", gnt2);
        end
    endtask

    task automatic test_error();
        req2 = 2'b11; hburst = 3'd3;
        for (int i = 0; i < 4; i++) begin
            htrans = (i == 0) ? 2'b10 : ((i < 3) ? 2'b11 : 2'b00);
            hready = (i != 2);
            tick();
            checks++;
            if (gnt2 !== ((i == 3) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL error_resp[%0d]: gnt=%b, want %b", i, gnt2, (i == 3) ? 2'b01 : 2'b10);
            end
        end
        hready = 1'b1;
    endtask

    task automatic test_req_drop();
        req2 = 2'b10; hburst = 3'd5;
        for (int i = 0; i < 8; i++) begin
            htrans = (i == 0) ? 2'b10 : 2'b11;
            tick();
            checks++;
            if (gnt2 !== ((i == 7) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL req_drop[%0d]: gnt=%b, want %b", i, gnt2, (i == 7) ? 2'b10 : 2'b01);
            end
        end
        req2 = 2'b00; htrans = 2'b00;
        tick();
    endtask

    task automatic test_n4();
        logic [1:0] eh;
        req4 = 4'b0100; htrans = 2'b00; hburst = 3'd0;
        tick();
        checks++;
        if (hm4 !== 2'd2 || gnt4 !== 4'b0100) begin
            errors++;
            $display("FAIL n4_setup: gnt=%b hm=%0d, want 0100 2", gnt4, hm4);
        end
        req4 = 4'b1111; htrans = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            eh = 2'((3 + i) % 4);
            checks++;
            if (hm4 !== eh || gnt4 !== (4'b0001 << eh)) begin
                errors++;
                $display("FAIL n4_rr[%0d]: gnt=%b hm=%0d, want hm=%0d", i, gnt4, hm4, eh);
            end
        end
        hburst = 3'd5; htrans = 2'b10;
        tick();
        htrans = 2'b11;
        tick();
        checks++;
        if (hm4 !== 2'd2) begin
            errors++;
            $display("FAIL n4_incr8: hm=%0d, want 2", hm4);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (gnt4 !== 4'b0001 || hm4 !== 2'd0 || hmd4 !== 2'd0) begin
            errors++;
            $display("FAIL n4_reset: gnt=%b hm=%0d hmd=%0d, want 0001 0 0", gnt4, hm4, hmd4);
        end
        // stale beat count would create a boundary within these SEQs
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (gnt4 !== 4'b0001) begin
                errors++;
                $display("FAIL n4_cnt_cleared[%0d]: gnt=%b, want 0001", i, gnt4);
            end
        end
        htrans = 2'b00; req4 = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        int r;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom % 80) == 0;
            req2   = 2'($urandom);
            req4   = 4'($urandom);
            r      = $urandom % 8;
            htrans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 4) ? 2'b10 : 2'b11;
            hburst = 3'($urandom);
            hlock  = ($urandom % 8) == 0;
            hready = ($urandom % 4) != 0;
            tick();
            checks++;
            if (gnt2 !== 2'(1 << m_own[0]) || hm2 !== 1'(m_own[0]) || hmd2 !== 1'(m_down[0])) begin
                errors++;
                $display("FAIL rand_n2[%0d]: gnt=%b hm=%0d hmd=%0d, want hm=%0d hmd=%0d", i, gnt2, hm2, hmd2, m_own[0], m_down[0]);
            end
            checks++;
            if (gnt4 !== 4'(1 << m_own[1]) || hm4 !== 2'(m_own[1]) || hmd4 !== 2'(m_down[1])) begin
                errors++;
                $display("FAIL rand_n4[%0d]: gnt=%b hm=%0d hmd=%0d, want hm=%0d hmd=%0d", i, gnt4, hm4, hmd4, m_own[1], m_down[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_incr4();
        test_alternate();
        test_hready_stall();
        test_lock();
        test_error();
        test_req_drop();
        test_n4();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
